mant_round_pipe: RTL and testbench
==================================

Name: mant_round_pipe

Overview:
Pipelined, parametrised mantissa rounding unit for the real multiplier datapath.
- Takes the wide product mantissa split into kept part and extension bits, plus sign and biased exponent.
- Rounds per one of four modes and renormalises on mantissa carry-out, incrementing the exponent and flagging exponent overflow.
- Streams through a 2-stage valid/ready pipeline with backpressure and accumulates sticky exception flags until cleared.

Parameters:
MANT_W, 24, kept mantissa width including hidden bit
EXT_W, 24, discarded low-order bits below mantissa LSB (>=2)
EXP_W, 8, biased exponent width; all-ones exponent is reserved (inf/NaN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active high
in_valid  input  1  input beat valid
in_ready  output  1  unit can accept a beat this cycle
in_mant  input  MANT_W  kept mantissa bits
in_ext  input  EXT_W  extension bits (MSB = guard)
in_exp  input  EXP_W  biased exponent, assumed < all-ones
in_sign  input  1  sign of result
in_mode  input  2  rounding mode, sampled per beat
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_mant  output  MANT_W  rounded mantissa
out_exp  output  EXP_W  adjusted exponent
out_sign  output  1  sign, passed through
out_inexact  output  1  this beat: in_ext != 0
out_mant_ovf  output  1  this beat: rounding carried out of mantissa
out_exp_ovf  output  1  this beat: exponent reached all-ones
flags_clr  input  1  synchronous clear of sticky flags
sticky_flags  output  3  {exp_ovf, mant_ovf, inexact}, accumulated

Behaviour:
- Reset (async, rst=1): both stage valids=0, out_valid=0, sticky_flags=0, out_mant/out_exp/out_sign/per-beat flags=0. in_ready=1 once rst deasserts.
- Handshake: beat accepted when in_valid&in_ready; result consumed when out_valid&out_ready.
- Payload stability: must hold while out_valid&~out_ready.
- Stage advance: S2 loads when ~v2 | out_ready. S1 loads when ~v1 | S2 loads. in_ready = S1 loads (combinational path from out_ready allowed).
- Latency: 2 cycles accept->out_valid with no stall. Throughput 1 beat/cycle. Order preserved, no beat dropped or duplicated.
- Stage 1 decode:
  - lsb = in_mant[0]; guard = in_ext[EXT_W-1]; sticky = |in_ext[EXT_W-2:0]; inexact = |in_ext.
  - Increment by mode:
    - 00 (toward zero): inc = 0.
    - 01 (toward +inf): inc = ~sign & inexact.
    - 10 (toward -inf): inc = sign & inexact.
    - 11 (nearest, ties to even): inc = guard & (sticky | lsb).
  - S1 registers mant, exp, sign, inc, inexact.
- Stage 2 arithmetic:
  - sum = {1'b0,mant} + inc, MANT_W+1 bits.
  - mant_ovf = sum[MANT_W]. On overflow: out_mant = {1'b1, zeros}, exp_n = exp + 1; otherwise out_mant = sum[MANT_W-1:0], exp_n = exp.
  - exp_ovf = mant_ovf & (exp_n == all-ones). On exp_ovf: out_exp = all-ones, out_mant = {1'b1, zeros} (infinity encoding); downstream handles saturation.
- Sticky flags: on each output handshake, sticky_flags |= {exp_ovf, mant_ovf, inexact} of the consumed beat.
  - flags_clr zeroes them next edge.
  - Clear and handshake in the same cycle: the result is exactly the handshake beat's flags.
- Mode/sign/exponent are per-beat; a mode change between beats never affects in-flight beats.
- Reset mid-stream: in-flight beats are discarded; no output handshake occurs for them.

Test Plan:
(All tests use MANT_W=8, EXT_W=4, EXP_W=4.)
- RNE tie: mant=0x2B, ext=1000, exp=3, mode 11 -> 2 cycles later mant=0x2C, exp=3, inexact=1. Repeat with mant=0x2A -> mant=0x2A, inexact=1.
- Directed modes: mant=0x2B, ext=0001. Mode 01 sign 0 -> 0x2C; mode 01 sign 1 -> 0x2B; mode 10 sign 1 -> 0x2C; mode 00 -> 0x2B. inexact=1 in all four. With ext=0000 -> 0x2B, inexact=0 in all modes.
- Mantissa carry: mant=0xFF, ext=1100, exp=3, mode 11 -> mant=0x80, exp=4, mant_ovf=1, exp_ovf=0.
- Exponent overflow: mant=0xFF, ext=1000, exp=14, mode 11 -> exp=15, mant=0x80, mant_ovf=1, exp_ovf=1, and sticky_flags=111 afterwards. Then flags_clr for 1 cycle -> sticky_flags=000.
- Backpressure: out_ready=0, stream 4 beats (mant 0x10..0x13, ext 0) -> in_ready falls after 2 accepted. Release out_ready -> outputs 0x10,0x11,0x12,0x13 in order, one per cycle, payload stable while stalled.
- Reset mid-operation: 2 beats in flight, assert rst asynchronously -> out_valid=0 immediately, sticky_flags=0. After release, a fresh beat emerges with 2-cycle latency and no stale beat appears.

Source files
------------

// File: rtl/mant_round_pipe.sv
// Two-stage mantissa rounding pipeline: stage 1 decodes the rounding increment,
// stage 2 adds it, renormalises on carry-out and flags exponent overflow.
module mant_round_pipe #(
  parameter int MANT_W = 24,
  parameter int EXT_W  = 24,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXT_W-1:0]  in_ext,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_sign,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_sign,
  output logic              out_inexact,
  output logic              out_mant_ovf,
  output logic              out_exp_ovf,
  input  logic              flags_clr,
  output logic [2:0]        sticky_flags
);

  typedef enum logic [1:0] {
    RM_RTZ = 2'b00,
    RM_RUP = 2'b01,
    RM_RDN = 2'b10,
    RM_RNE = 2'b11
  } round_mode_e;

  localparam logic [MANT_W-1:0] MANT_CARRY = {1'b1, {(MANT_W-1){1'b0}}};

  logic s1_load, s2_load;
  logic v1, v2;

  logic [MANT_W-1:0] s1_mant;
  logic [EXP_W-1:0]  s1_exp;
  logic              s1_sign, s1_inc, s1_inexact;

  // Stage-advance chain: a full stage frees up when the one below it moves.
  assign s2_load   = ~v2 | out_ready;
  assign s1_load   = ~v1 | s2_load;
  assign in_ready  = s1_load;
  assign out_valid = v2;

  // ---------------- Stage 1 decode ----------------
  logic lsb, guard, sticky, inexact, inc;

  assign lsb     = in_mant[0];
  assign guard   = in_ext[EXT_W-1];
  assign sticky  = |in_ext[EXT_W-2:0];
  assign inexact = |in_ext;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    inc = 1'b0;
    case (round_mode_e'(in_mode))
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = ~in_sign & inexact;
      RM_RDN:  inc = in_sign & inexact;
      RM_RNE:  inc = guard & (sticky | lsb);
      default: inc = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1         <= 1'b0;
      s1_mant    <= '0;
      s1_exp     <= '0;
      s1_sign    <= 1'b0;
      s1_inc     <= 1'b0;
      s1_inexact <= 1'b0;
    end else if (s1_load) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_mant    <= in_mant;
        s1_exp     <= in_exp;
        s1_sign    <= in_sign;
        s1_inc     <= inc;
        s1_inexact <= inexact;
      end
    end
  end

  // ---------------- Stage 2 arithmetic ----------------
  logic [MANT_W:0]   sum;
  logic              mant_ovf, exp_ovf;
  logic [EXP_W-1:0]  exp_n;
  logic [MANT_W-1:0] mant_n;

  assign sum      = {1'b0, s1_mant} + {{MANT_W{1'b0}}, s1_inc};
  assign mant_ovf = sum[MANT_W];
  assign exp_n    = mant_ovf ? s1_exp + EXP_W'(1) : s1_exp;
  // A carried-out mantissa is always 1.00..0; with an all-ones exponent that is the infinity encoding.
  assign exp_ovf  = mant_ovf & (&exp_n);
  assign mant_n   = mant_ovf ? MANT_CARRY : sum[MANT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2           <= 1'b0;
      out_mant     <= '0;
      out_exp      <= '0;
      out_sign     <= 1'b0;
      out_inexact  <= 1'b0;
      out_mant_ovf <= 1'b0;
      out_exp_ovf  <= 1'b0;
    end else if (s2_load) begin
      v2 <= v1;
      if (v1) begin
        out_mant     <= mant_n;
        out_exp      <= exp_n;
        out_sign     <= s1_sign;
        out_inexact  <= s1_inexact;
        out_mant_ovf <= mant_ovf;
        out_exp_ovf  <= exp_ovf;
      end
    end
  end

  // ---------------- Sticky exception flags ----------------
  logic       out_hs;
  logic [2:0] beat_flags;

  assign out_hs     = v2 & out_ready;
  assign beat_flags = out_hs ? {out_exp_ovf, out_mant_ovf, out_inexact} : 3'b000;

  // A clear coinciding with a handshake keeps only that beat's flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= 3'b000;
    end else if (flags_clr) begin
      sticky_flags <= beat_flags;
    end else begin
      sticky_flags <= sticky_flags | beat_flags;
    end
  end

endmodule

// File: tb/tb_mant_round_pipe.sv
// Self-checking bench for mant_round_pipe (MANT_W=8, EXT_W=4, EXP_W=4): directed
// rounding/overflow/backpressure/reset steps followed by a randomized scoreboard run.
module tb_mant_round_pipe;

  localparam int MW = 8;
  localparam int XW = 4;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [MW-1:0] in_mant = '0;
  logic [XW-1:0] in_ext = '0;
  logic [EW-1:0] in_exp = '0;
  logic          in_sign = 1'b0;
  logic [1:0]    in_mode = 2'b00;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [MW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  logic          out_sign;
  logic          out_inexact;
  logic          out_mant_ovf;
  logic          out_exp_ovf;
  logic          flags_clr = 1'b0;
  logic [2:0]    sticky_flags;

  mant_round_pipe #(.MANT_W(MW), .EXT_W(XW), .EXP_W(EW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_ext(in_ext), .in_exp(in_exp),
    .in_sign(in_sign), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp), .out_sign(out_sign),
    .out_inexact(out_inexact), .out_mant_ovf(out_mant_ovf), .out_exp_ovf(out_exp_ovf),
    .flags_clr(flags_clr), .sticky_flags(sticky_flags)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [MW-1:0] mant;
    logic [EW-1:0] exp;
    logic          sign;
    logic [2:0]    flags; // {exp_ovf, mant_ovf, inexact}
  } res_t;

  res_t exp_q[$];

  // Rounding expressed as arithmetic on the real value mant + ext/2^XW.
  function automatic res_t model(int m, int x, int e, bit s, int md);
    res_t r;
    int   half = 1 << (XW - 1);
    bit   inexact = (x != 0);
    bit   up;
    int   val;
    int   ex = e;
    bit   mo = 0;
    bit   eo = 0;
    case (md)
      0:       up = 0;
      1:       up = !s && inexact;
      2:       up = s && inexact;
      default: up = (x > half) || (x == half && (m % 2) == 1);
    endcase
    val = m + (up ? 1 : 0);
    if (val == (1 << MW)) begin
      val = 1 << (MW - 1);
      ex  = e + 1;
      mo  = 1;
      eo  = (ex == (1 << EW) - 1);
    end
    r.mant  = MW'(val);
    r.exp   = EW'(ex);
    r.sign  = s;
    r.flags = {eo, mo, inexact};
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Called at a falling edge with an empty pipe and out_ready=1; returns at a falling edge, beat consumed.
  task automatic single_beat(input string tag, input int m, input int x, input int e,
                             input bit s, input int md, input int want_mant);
    res_t r = model(m, x, e, s, md);
    in_mant = MW'(m); in_ext = XW'(x); in_exp = EW'(e); in_sign = s; in_mode = 2'(md);
    in_valid = 1'b1;
    #1 check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    #1 check({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    #1;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_mant"}, 32'(out_mant), 32'(r.mant));
    if (want_mant >= 0) check({tag, "_mant_const"}, 32'(out_mant), 32'(want_mant));
    check({tag, "_exp"}, 32'(out_exp), 32'(r.exp));
    check({tag, "_sign"}, 32'(out_sign), 32'(r.sign));
    check({tag, "_flags"}, 32'({out_exp_ovf, out_mant_ovf, out_inexact}), 32'(r.flags));
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    int   sent, got;
    bit   hs;
    logic [2:0] exp_sticky;

    // Reset state
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sticky", 32'(sticky_flags), 32'd0);
    check("rst_payload", 32'({out_mant, out_exp, out_sign, out_inexact, out_mant_ovf, out_exp_ovf}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Round-to-nearest-even ties
    single_beat("rne_tie_odd", 'h2B, 'b1000, 3, 0, 3, 'h2C);
    single_beat("rne_tie_even", 'h2A, 'b1000, 3, 0, 3, 'h2A);

    // Directed modes with a sticky-only extension, then exact inputs
    single_beat("rup_pos", 'h2B, 'b0001, 5, 0, 1, 'h2C);
    single_beat("rup_neg", 'h2B, 'b0001, 5, 1, 1, 'h2B);
    single_beat("rdn_neg", 'h2B, 'b0001, 5, 1, 2, 'h2C);
    single_beat("rtz", 'h2B, 'b0001, 5, 0, 0, 'h2B);
    for (int md = 0; md < 4; md++) single_beat("exact", 'h2B, 0, 5, md[0], md, 'h2B);

    // Mantissa carry, then exponent overflow
    single_beat("mant_carry", 'hFF, 'b1100, 3, 0, 3, 'h80);
    single_beat("exp_ovf", 'hFF, 'b1000, 14, 0, 3, 'h80);
    check("exp_ovf_out_exp", 32'(out_exp), 32'd15);
    check("exp_ovf_sticky", 32'(sticky_flags), 32'b111);
    flags_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    flags_clr = 1'b0;
    #1 check("flags_clr", 32'(sticky_flags), 32'b000);

    // Backpressure: only two beats fit while the output stalls
    out_ready = 1'b0;
    in_ext = '0; in_exp = 4'd2; in_sign = 1'b0; in_mode = 2'b11;
    sent = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_mant = MW'(8'h10 + sent);
      #1;
      check($sformatf("bp_in_ready_%0d", i), 32'(in_ready), (i < 2) ? 32'd1 : 32'd0);
      if (i == 3) begin
        check("bp_stall_valid", 32'(out_valid), 32'd1);
        check("bp_stall_mant", 32'(out_mant), 32'h10);
      end
      if (in_ready) sent++;
      @(posedge clk);
    end
    got = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = (sent < 4);
      in_mant = MW'(8'h10 + sent);
      #1;
      check($sformatf("bp_drain_valid_%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_drain_mant_%0d", i), 32'(out_mant), 32'h10 + 32'(got));
      got++;
      if (in_valid && in_ready) sent++;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("bp_empty", 32'(out_valid), 32'd0);
    check("bp_sent", 32'(sent), 32'd4);

    // Randomized stream against the reference model and a sticky-flag model
    @(negedge clk);
    flags_clr = 1'b1;
    @(posedge clk);
    exp_sticky = 3'b000;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      flags_clr = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_mant   = ($urandom_range(0, 3) == 0) ? 8'hFF : MW'($urandom);
      in_ext    = XW'($urandom);
      in_exp    = ($urandom_range(0, 3) == 0) ? 4'd14 : EW'($urandom_range(0, 14));
      in_sign   = 1'($urandom);
      in_mode   = 2'($urandom);
      #1;
      check("rnd_sticky", 32'(sticky_flags), 32'(exp_sticky));
      hs = out_valid && out_ready;
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("rnd_spurious_out", 32'(out_valid), 32'd0);
          hs = 0;
        end else begin
          r = exp_q.pop_front();
          check("rnd_beat", 32'({out_sign, out_exp, out_mant, out_exp_ovf, out_mant_ovf, out_inexact}),
                32'({r.sign, r.exp, r.mant, r.flags}));
        end
      end
      if (flags_clr) exp_sticky = hs ? r.flags : 3'b000;
      else if (hs)   exp_sticky = exp_sticky | r.flags;
      if (in_valid && in_ready) exp_q.push_back(model(in_mant, in_ext, in_exp, in_sign, in_mode));
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0; flags_clr = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) check("drain_spurious_out", 32'(out_valid), 32'd0);
        else begin
          r = exp_q.pop_front();
          check("drain_beat", 32'({out_sign, out_exp, out_mant, out_exp_ovf, out_mant_ovf, out_inexact}),
                32'({r.sign, r.exp, r.mant, r.flags}));
        end
      end
      @(posedge clk); @(negedge clk);
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset with two beats in flight
    flags_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    flags_clr = 1'b0;
    single_beat("pre_rst", 'h31, 'b0001, 6, 0, 0, 'h31);
    check("pre_rst_sticky", 32'(sticky_flags), 32'b001);
    out_ready = 1'b0;
    in_valid = 1'b1; in_mant = 8'h55; in_ext = 4'b0110;
    @(posedge clk); @(negedge clk);
    in_mant = 8'h56;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    #1 check("mid_rst_inflight", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sticky", 32'(sticky_flags), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("post_rst_idle_%0d", i), 32'(out_valid), 32'd0);
      @(posedge clk); @(negedge clk);
    end
    single_beat("post_rst", 'h7E, 'b1001, 9, 1, 3, 'h7F);
    check("post_rst_sticky", 32'(sticky_flags), 32'b001);
    #1 check("post_rst_no_stale", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
